// File: rtl/alu_alloc_pkg.sv
// Shared helpers for the ALU pool allocator: age compare on wrapping issue ids
// and the ALU/port index width rule (clog2, but never narrower than one bit).
// Latency: n/a (functions only). Backpressure: n/a.
package alu_alloc_pkg;

  // Width of an index into a pool of n entries; a pool of one still needs a bit.
  function automatic int idx_w(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // a is older than b when (a - b) mod 2^w has its MSB set. Callers zero-extend
  // their w-bit ids to 32 bits; bit w-1 of the 32-bit difference equals bit w-1
  // of the modulo-2^w difference.
  function automatic logic is_older(logic [31:0] a, logic [31:0] b, int w);
    logic [31:0] diff;
    diff = a - b;
    return diff[w-1];
  endfunction

endpackage

// File: rtl/alu_allocator_if.sv
// Requester/allocator bus for the ALU pool: per-port request, issue id and
// release in; per-port grant plus pool occupancy out.
// Latency: n/a (wires only). Backpressure: req is a level held until granted.
interface alu_allocator_if #(
  parameter int NUM_PORTS = 4,
  parameter int NUM_ALUS  = 4,
  parameter int ID_WIDTH  = 4
);
  import alu_alloc_pkg::*;

  localparam int AW = idx_w(NUM_ALUS);
  localparam int FW = $clog2(NUM_ALUS + 1);

  logic [NUM_PORTS-1:0]                req;
  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]  req_issue_id;
  logic [NUM_PORTS-1:0]                alu_release;  // one-cycle pulse, returns the port's ALU
  logic                                flush;
  logic [NUM_PORTS-1:0]                alloc_valid;
  logic [NUM_PORTS-1:0][AW-1:0]        alloc_alu_id;
  logic [NUM_ALUS-1:0]                 alu_busy;
  logic [FW-1:0]                       free_count;

  modport master (
    output req, req_issue_id, alu_release, flush,
    input  alloc_valid, alloc_alu_id, alu_busy, free_count
  );

  modport slave (
    input  req, req_issue_id, alu_release, flush,
    output alloc_valid, alloc_alu_id, alu_busy, free_count
  );
endinterface

// File: rtl/age_rank.sv
// Ranks allocation candidates by age: rank[p] = number of candidates older than p
// (older issue id first, equal ids broken by lower port index).
// Latency: combinational. Backpressure: none.
//   cand     : candidate mask
//   issue_id : per-port issue sequence number
//   rank     : per-port count of older candidates (meaningful only where cand=1)
module age_rank
  import alu_alloc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 4,
  parameter int RW        = 2
) (
  input  logic [NUM_PORTS-1:0]               cand,
  input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] issue_id,
  output logic [NUM_PORTS-1:0][RW-1:0]       rank
);

  always_comb begin
    rank = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (cand[q] && (q != p)) begin
          if (is_older(32'(issue_id[q]), 32'(issue_id[p]), ID_WIDTH) ||
              ((issue_id[q] == issue_id[p]) && (q < p))) begin
            rank[p] = rank[p] + RW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/alu_allocator.sv
// Dynamic ALU pool scheduler: grants any free ALU to requesting ports, oldest
// issue id first, and holds it until the port releases it or a flush.
// Latency: one cycle req->alloc_valid. Backpressure: ungranted requesters simply retry each cycle.
//   clk, rst_n : clock and async active-low reset
//   bus        : slave side of alu_allocator_if (req/id/release/flush in, grants out)
module alu_allocator
  import alu_alloc_pkg::*;
#(
  parameter int NUM_ALUS  = 4,
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_allocator_if.slave  bus
);

  localparam int AW = idx_w(NUM_ALUS);
  localparam int RW = idx_w(NUM_PORTS);
  localparam int FW = $clog2(NUM_ALUS + 1);

  logic [NUM_PORTS-1:0]          own_q, own_d;
  logic [NUM_PORTS-1:0][AW-1:0]  alu_id_q, alu_id_d;
  logic [NUM_ALUS-1:0]           busy_q, busy_d;

  logic [NUM_PORTS-1:0]          cand;
  logic [NUM_PORTS-1:0][RW-1:0]  rank;
  int                            nf;
  logic                          dup_own;

  // A releasing port is never a candidate, even with req held high.
  assign cand = bus.req & ~own_q & ~bus.alu_release;

  age_rank #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH),
    .RW        (RW)
  ) u_age_rank (
    .cand     (cand),
    .issue_id (bus.req_issue_id),
    .rank     (rank)
  );

  always_comb begin
    own_d    = own_q;
    alu_id_d = alu_id_q;
    busy_d   = busy_q;
    nf       = 0;
    if (bus.flush) begin
      own_d    = '0;
      alu_id_d = '0;
      busy_d   = '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (own_q[p] && bus.alu_release[p]) begin
          own_d[p]              = 1'b0;
          busy_d[alu_id_q[p]]   = 1'b0;
        end
      end
      // Rank k takes the k-th lowest free ALU. The free list comes from busy_q,
      // so an ALU released this cycle only becomes allocatable next cycle.
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (cand[p]) begin
          nf = 0;
          for (int a = 0; a < NUM_ALUS; a++) begin
            if (!busy_q[a]) begin
              if (nf == int'(rank[p])) begin
                own_d[p]    = 1'b1;
                alu_id_d[p] = AW'(a);
                busy_d[a]   = 1'b1;
              end
              nf = nf + 1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q    <= '0;
      alu_id_q <= '0;
      busy_q   <= '0;
    end else begin
      own_q    <= own_d;
      alu_id_q <= alu_id_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.alloc_valid  = own_q;
  assign bus.alloc_alu_id = alu_id_q;
  assign bus.alu_busy     = busy_q;
  assign bus.free_count   = FW'(NUM_ALUS) - FW'($countones(busy_q));

  always_comb begin
    dup_own = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = p + 1; q < NUM_PORTS; q++) begin
        if (own_q[p] && own_q[q] && (alu_id_q[p] == alu_id_q[q])) dup_own = 1'b1;
      end
    end
  end

  a_unique_owner: assert property (@(posedge clk) disable iff (!rst_n) !dup_own);
  a_busy_matches_owners: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(busy_q) == $countones(own_q));
  a_free_count: assert property (@(posedge clk) disable iff (!rst_n)
    int'(bus.free_count) == NUM_ALUS - $countones(busy_q));

endmodule

// File: tb/tb_alu_allocator.sv
module tb_alu_allocator;
  localparam int NP  = 4;
  localparam int NA  = 4;
  localparam int IDW = 4;
  localparam int MOD = 1 << IDW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_allocator_if #(.NUM_PORTS(NP), .NUM_ALUS(NA), .ID_WIDTH(IDW)) bus ();

  alu_allocator #(.NUM_ALUS(NA), .NUM_PORTS(NP), .ID_WIDTH(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: per-port ownership and ALU, per-ALU busy flag.
  bit m_own[NP];
  int m_alu[NP];
  bit m_busy[NA];

  function automatic bit older(int a, int b);
    return (((a - b) % MOD + MOD) % MOD) >= (MOD / 2);
  endfunction

  function automatic bit goes_first(int p, int q);
    int ip, iq;
    ip = int'(bus.req_issue_id[p]);
    iq = int'(bus.req_issue_id[q]);
    return older(ip, iq) || (ip == iq && p < q);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin m_own[p] = 0; m_alu[p] = 0; end
    for (int a = 0; a < NA; a++) m_busy[a] = 0;
  endtask

  task automatic model_step();
    bit pre_own[NP];
    int freeq[$];
    int cq[$];
    int pos;
    for (int p = 0; p < NP; p++) pre_own[p] = m_own[p];
    for (int a = 0; a < NA; a++) if (!m_busy[a]) freeq.push_back(a);
    if (bus.flush) begin
      model_reset();
      return;
    end
    for (int p = 0; p < NP; p++)
      if (m_own[p] && bus.alu_release[p]) begin m_own[p] = 0; m_busy[m_alu[p]] = 0; end
    for (int p = 0; p < NP; p++) begin
      if (bus.req[p] && !pre_own[p] && !bus.alu_release[p]) begin
        pos = cq.size();
        for (int i = cq.size() - 1; i >= 0; i--) if (goes_first(p, cq[i])) pos = i;
        cq.insert(pos, p);
      end
    end
    for (int k = 0; k < cq.size() && k < freeq.size(); k++) begin
      m_own[cq[k]] = 1; m_alu[cq[k]] = freeq[k]; m_busy[freeq[k]] = 1;
    end
  endtask

  function automatic logic [NP-1:0] exp_valid();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = m_own[p];
    return v;
  endfunction

  function automatic logic [NA-1:0] exp_busy();
    logic [NA-1:0] v;
    for (int a = 0; a < NA; a++) v[a] = m_busy[a];
    return v;
  endfunction

  function automatic int exp_free();
    int n = 0;
    for (int a = 0; a < NA; a++) if (!m_busy[a]) n++;
    return n;
  endfunction

  task automatic clear_inputs();
    bus.req = '0; bus.req_issue_id = '0; bus.alu_release = '0; bus.flush = 1'b0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++; if (bus.alloc_valid !== 4'b0000) begin fails++; $display("FAIL reset_valid got %b want 0000", bus.alloc_valid); end
    tests++; if (bus.alloc_alu_id !== '0) begin fails++; $display("FAIL reset_ids got %h want 0", bus.alloc_alu_id); end
    tests++; if (bus.alu_busy !== 4'b0000) begin fails++; $display("FAIL reset_busy got %b want 0000", bus.alu_busy); end
    tests++; if (bus.free_count !== 3'd4) begin fails++; $display("FAIL reset_free got %0d want 4", bus.free_count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_grant();
    do_reset();
    bus.req[0] = 1'b1; bus.req_issue_id[0] = 4'd3;
    step();
    bus.req = '0;
    tests++; if (bus.alloc_valid !== 4'b0001) begin fails++; $display("FAIL single_valid got %b want 0001", bus.alloc_valid); end
    tests++; if (bus.alloc_alu_id[0] !== 2'd0) begin fails++; $display("FAIL single_id got %0d want 0", bus.alloc_alu_id[0]); end
    tests++; if (bus.alu_busy !== 4'b0001) begin fails++; $display("FAIL single_busy got %b want 0001", bus.alu_busy); end
    tests++; if (bus.free_count !== 3'd3) begin fails++; $display("FAIL single_free got %0d want 3", bus.free_count); end
  endtask

  task automatic test_age_order();
    do_reset();
    bus.req = 4'b1111;
    bus.req_issue_id[0] = 4'd5; bus.req_issue_id[1] = 4'd2;
    bus.req_issue_id[2] = 4'd7; bus.req_issue_id[3] = 4'd2;
    step();
    bus.req = '0;
    // Order by age: p1(2), p3(2, tie by index), p0(5), p2(7).
    tests++; if (bus.alloc_alu_id[1] !== 2'd0) begin fails++; $display("FAIL age_p1 got %0d want 0", bus.alloc_alu_id[1]); end
    tests++; if (bus.alloc_alu_id[3] !== 2'd1) begin fails++; $display("FAIL age_p3 got %0d want 1", bus.alloc_alu_id[3]); end
    tests++; if (bus.alloc_alu_id[0] !== 2'd2) begin fails++; $display("FAIL age_p0 got %0d want 2", bus.alloc_alu_id[0]); end
    tests++; if (bus.alloc_alu_id[2] !== 2'd3) begin fails++; $display("FAIL age_p2 got %0d want 3", bus.alloc_alu_id[2]); end
    tests++; if (bus.free_count !== 3'd0) begin fails++; $display("FAIL age_free got %0d want 0", bus.free_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 4'b0011; bus.req_issue_id[0] = 4'd14; bus.req_issue_id[1] = 4'd1;
    step();
    bus.req = '0;
    tests++; if (bus.alloc_alu_id[0] !== 2'd0) begin fails++; $display("FAIL wrap_p0 got %0d want 0", bus.alloc_alu_id[0]); end
    tests++; if (bus.alloc_alu_id[1] !== 2'd1) begin fails++; $display("FAIL wrap_p1 got %0d want 1", bus.alloc_alu_id[1]); end
    do_reset();
    bus.req = 4'b0011; bus.req_issue_id[0] = 4'd1; bus.req_issue_id[1] = 4'd14;
    step();
    bus.req = '0;
    tests++; if (bus.alloc_alu_id[1] !== 2'd0) begin fails++; $display("FAIL wrap_rev_p1 got %0d want 0", bus.alloc_alu_id[1]); end
  endtask

  task automatic test_release_reuse();
    do_reset();
    bus.req = 4'b1111;
    for (int p = 0; p < NP; p++) bus.req_issue_id[p] = IDW'(p);
    step();
    bus.req = '0;
    step();
    bus.alu_release[2] = 1'b1; bus.req[2] = 1'b1; bus.req_issue_id[2] = 4'd9;
    step();
    bus.alu_release = '0;
    tests++; if (bus.alu_busy !== 4'b1011) begin fails++; $display("FAIL rel_busy got %b want 1011", bus.alu_busy); end
    tests++; if (bus.alloc_valid !== 4'b1011) begin fails++; $display("FAIL rel_valid got %b want 1011", bus.alloc_valid); end
    step();
    bus.req = '0;
    tests++; if (bus.alloc_valid !== 4'b1111) begin fails++; $display("FAIL reuse_valid got %b want 1111", bus.alloc_valid); end
    tests++; if (bus.alloc_alu_id[2] !== 2'd2) begin fails++; $display("FAIL reuse_id got %0d want 2", bus.alloc_alu_id[2]); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    bus.req = 4'b0111;
    for (int p = 0; p < NP; p++) bus.req_issue_id[p] = IDW'(p + 1);
    step();
    bus.req = 4'b1000; bus.flush = 1'b1; bus.alu_release[0] = 1'b1;
    step();
    clear_inputs();
    tests++; if (bus.alu_busy !== 4'b0000) begin fails++; $display("FAIL flush_busy got %b want 0000", bus.alu_busy); end
    tests++; if (bus.alloc_valid !== 4'b0000) begin fails++; $display("FAIL flush_valid got %b want 0000", bus.alloc_valid); end
    tests++; if (bus.free_count !== 3'd4) begin fails++; $display("FAIL flush_free got %0d want 4", bus.free_count); end
    bus.req = 4'b0111;
    step();
    bus.req = '0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    tests++; if (bus.alloc_valid !== 4'b0000) begin fails++; $display("FAIL arst_valid got %b want 0000", bus.alloc_valid); end
    tests++; if (bus.alu_busy !== 4'b0000) begin fails++; $display("FAIL arst_busy got %b want 0000", bus.alu_busy); end
    tests++; if (bus.alloc_alu_id !== '0) begin fails++; $display("FAIL arst_ids got %h want 0", bus.alloc_alu_id); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_ignored();
    do_reset();
    bus.req[1] = 1'b1; bus.req_issue_id[1] = 4'd0;
    step();
    bus.req = '0;
    bus.alu_release[0] = 1'b1; bus.req[1] = 1'b1; bus.req_issue_id[1] = 4'd5;
    step();
    clear_inputs();
    tests++; if (bus.alloc_valid !== 4'b0010) begin fails++; $display("FAIL ign_valid got %b want 0010", bus.alloc_valid); end
    tests++; if (bus.alloc_alu_id[1] !== 2'd0) begin fails++; $display("FAIL ign_id got %0d want 0", bus.alloc_alu_id[1]); end
    tests++; if (bus.alu_busy !== 4'b0001) begin fails++; $display("FAIL ign_busy got %b want 0001", bus.alu_busy); end
  endtask

  task automatic test_random();
    int base = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 3) == 0) base = (base + 1) % MOD;
      for (int p = 0; p < NP; p++) begin
        bus.req[p]          = 1'($urandom_range(0, 1));
        bus.req_issue_id[p] = IDW'((base + int'($urandom_range(0, 6))) % MOD);
        bus.alu_release[p]  = 1'($urandom_range(0, 3) == 0);
      end
      bus.flush = 1'($urandom_range(0, 49) == 0);
      step();
      tests++; if (bus.alloc_valid !== exp_valid()) begin fails++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, bus.alloc_valid, exp_valid()); end
      tests++; if (bus.alu_busy !== exp_busy()) begin fails++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, bus.alu_busy, exp_busy()); end
      tests++; if (int'(bus.free_count) !== exp_free()) begin fails++; $display("FAIL rnd_free cyc %0d got %0d want %0d", cyc, bus.free_count, exp_free()); end
      for (int p = 0; p < NP; p++) begin
        if (m_own[p]) begin
          tests++;
          if (int'(bus.alloc_alu_id[p]) !== m_alu[p]) begin
            fails++; $display("FAIL rnd_id cyc %0d port %0d got %0d want %0d", cyc, p, bus.alloc_alu_id[p], m_alu[p]);
          end
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_grant();
    test_age_order();
    test_wrap();
    test_release_reuse();
    test_flush_reset();
    test_ignored();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
